// File: rtl/m72_int_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : m72_int_seq_if
// Description : Handshake bundle between the interrupt acceptance sequencer
//               and its two neighbours. It carries the PIC request/vector/ack
//               handshake and the CPU bus transfer signals.
//                 master : the sequencer (drives int_ack and the bus request)
//                 slave  : the PIC and memory side (drive the request/vector
//                          and the bus read data/ack)
//               Ports carried:
//                 int_req    1   PIC request
//                 int_vector 9   vector-table byte address
//                 int_ack    1   acknowledge to the PIC
//                 bus_req    1   bus transfer request
//                 bus_wr     1   1 = write, 0 = read
//                 bus_addr   20  physical word address
//                 bus_dout   16  write data
//                 bus_din    16  read data
//                 bus_ack    1   transfer complete
// Revision    : 1.0 - initial release
// ============================================================================
interface m72_int_seq_if;
    logic        int_req;
    logic [8:0]  int_vector;
    logic        int_ack;
    logic        bus_req;
    logic        bus_wr;
    logic [19:0] bus_addr;
    logic [15:0] bus_dout;
    logic [15:0] bus_din;
    logic        bus_ack;

    modport master (
        input  int_req,
        input  int_vector,
        output int_ack,
        output bus_req,
        output bus_wr,
        output bus_addr,
        output bus_dout,
        input  bus_din,
        input  bus_ack
    );

    modport slave (
        output int_req,
        output int_vector,
        input  int_ack,
        input  bus_req,
        input  bus_wr,
        input  bus_addr,
        input  bus_dout,
        output bus_din,
        output bus_ack
    );
endinterface
`default_nettype wire

// File: rtl/m72_int_seq.sv
`default_nettype none
// ============================================================================
// Module      : m72_int_seq
// Description : CPU-side interrupt acceptance sequencer for the M72 V30 core.
//               At an instruction boundary with IF set it acknowledges the
//               PIC, pushes PSW/CS/IP, reads the new IP:CS pair from the
//               vector table and hands the results to the execution unit.
// Ports       :
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   ce         in   clock enable; state only advances on ce edges
//   bus        --   m72_int_seq_if.master (PIC handshake + CPU bus)
//   boundary   in   core is at an interruptible instruction boundary
//   if_flag    in   interrupt enable flag
//   psw, cs_in, ip_in, ss_in, sp_in  in 16  current core registers
//   busy       out  sequence in progress (core stalls)
//   done       out  one-cycle pulse, new_ip/new_cs/new_sp valid
//   clr_if     out  pulse with done; core clears IF and TF
//   new_ip, new_cs, new_sp  out 16  register values for the core to load
// Revision    : 1.0 - initial release
// ============================================================================
module m72_int_seq (
    input  wire logic         clk,
    input  wire logic         reset_n,
    input  wire logic         ce,
    m72_int_seq_if.master     bus,
    input  wire logic         boundary,
    input  wire logic         if_flag,
    input  wire logic [15:0]  psw,
    input  wire logic [15:0]  cs_in,
    input  wire logic [15:0]  ip_in,
    input  wire logic [15:0]  ss_in,
    input  wire logic [15:0]  sp_in,
    output logic              busy,
    output logic              done,
    output logic              clr_if,
    output logic [15:0]       new_ip,
    output logic [15:0]       new_cs,
    output logic [15:0]       new_sp
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACK      = 3'd1,
        ST_PUSH_PSW = 3'd2,
        ST_PUSH_CS  = 3'd3,
        ST_PUSH_IP  = 3'd4,
        ST_RD_IP    = 3'd5,
        ST_RD_CS    = 3'd6,
        ST_DONE     = 3'd7
    } state_t;

    state_t       r_state;

    // Snapshot of the core context taken on the trigger edge
    logic [8:0]   r_vec;
    logic [15:0]  r_ss;
    logic [15:0]  r_sp;
    logic [15:0]  r_psw;
    logic [15:0]  r_cs;
    logic [15:0]  r_ip;
    // New IP is held here until the CS read finishes so that all three
    // new_* outputs change together at DONE
    logic [15:0]  r_rd_ip;

    logic         r_int_ack;
    logic         r_busy;
    logic         r_bus_req;
    logic         r_bus_wr;
    logic [19:0]  r_bus_addr;
    logic [15:0]  r_bus_dout;
    logic         r_done;
    logic         r_clr_if;
    logic [15:0]  r_new_ip;
    logic [15:0]  r_new_cs;
    logic [15:0]  r_new_sp;

    logic         w_trigger;
    logic         w_xfer_done;
    logic [15:0]  w_sp_dec;
    logic [19:0]  w_push_addr;
    logic [19:0]  w_vec_addr;

    assign w_trigger   = boundary & if_flag & bus.int_req;
    // bus_ack only counts while a request is outstanding
    assign w_xfer_done = r_bus_req & bus.bus_ack;
    // Each push pre-decrements SP; the address is formed from the
    // decremented value, wrapping at 64K within the segment and at 1M overall
    assign w_sp_dec    = r_sp - 16'd2;
    assign w_push_addr = {r_ss, 4'h0} + {4'h0, w_sp_dec};
    assign w_vec_addr  = {11'h000, r_vec};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_vec      <= 9'h000;
            r_ss       <= 16'h0000;
            r_sp       <= 16'h0000;
            r_psw      <= 16'h0000;
            r_cs       <= 16'h0000;
            r_ip       <= 16'h0000;
            r_rd_ip    <= 16'h0000;
            r_int_ack  <= 1'b0;
            r_busy     <= 1'b0;
            r_bus_req  <= 1'b0;
            r_bus_wr   <= 1'b0;
            r_bus_addr <= 20'h00000;
            r_bus_dout <= 16'h0000;
            r_done     <= 1'b0;
            r_clr_if   <= 1'b0;
            r_new_ip   <= 16'h0000;
            r_new_cs   <= 16'h0000;
            r_new_sp   <= 16'h0000;
        end else if (ce) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_vec     <= bus.int_vector;
                        r_ss      <= ss_in;
                        r_sp      <= sp_in;
                        r_psw     <= psw;
                        r_cs      <= cs_in;
                        r_ip      <= ip_in;
                        r_busy    <= 1'b1;
                        r_int_ack <= 1'b1;
                        r_state   <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    // Present the PSW push in the cycle after the ack pulse
                    r_int_ack  <= 1'b0;
                    r_sp       <= w_sp_dec;
                    r_bus_req  <= 1'b1;
                    r_bus_wr   <= 1'b1;
                    r_bus_addr <= w_push_addr;
                    r_bus_dout <= r_psw;
                    r_state    <= ST_PUSH_PSW;
                end

                ST_PUSH_PSW: begin
                    if (w_xfer_done) begin
                        r_sp       <= w_sp_dec;
                        r_bus_addr <= w_push_addr;
                        r_bus_dout <= r_cs;
                        r_state    <= ST_PUSH_CS;
                    end
                end

                ST_PUSH_CS: begin
                    if (w_xfer_done) begin
                        r_sp       <= w_sp_dec;
                        r_bus_addr <= w_push_addr;
                        r_bus_dout <= r_ip;
                        r_state    <= ST_PUSH_IP;
                    end
                end

                ST_PUSH_IP: begin
                    if (w_xfer_done) begin
                        r_bus_wr   <= 1'b0;
                        r_bus_addr <= w_vec_addr;
                        r_state    <= ST_RD_IP;
                    end
                end

                ST_RD_IP: begin
                    if (w_xfer_done) begin
                        r_rd_ip    <= bus.bus_din;
                        r_bus_addr <= w_vec_addr + 20'd2;
                        r_state    <= ST_RD_CS;
                    end
                end

                ST_RD_CS: begin
                    if (w_xfer_done) begin
                        r_bus_req <= 1'b0;
                        r_new_ip  <= r_rd_ip;
                        r_new_cs  <= bus.bus_din;
                        r_new_sp  <= r_sp;
                        r_done    <= 1'b1;
                        r_clr_if  <= 1'b1;
                        r_state   <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_done   <= 1'b0;
                    r_clr_if <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end

                default: begin
                    r_int_ack <= 1'b0;
                    r_bus_req <= 1'b0;
                    r_done    <= 1'b0;
                    r_clr_if  <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.int_ack  = r_int_ack;
    assign bus.bus_req  = r_bus_req;
    assign bus.bus_wr   = r_bus_wr;
    assign bus.bus_addr = r_bus_addr;
    assign bus.bus_dout = r_bus_dout;
    assign busy         = r_busy;
    assign done         = r_done;
    assign clr_if       = r_clr_if;
    assign new_ip       = r_new_ip;
    assign new_cs       = r_new_cs;
    assign new_sp       = r_new_sp;

endmodule
`default_nettype wire

// File: tb/tb_m72_int_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_m72_int_seq
// Description : Self-checking bench for m72_int_seq. Each sequence issued
//               pushes its expected bus transfers and results into queues;
//               a monitor pops and compares as the DUT presents them. A
//               memory responder supplies read data with programmable waits.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_m72_int_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        boundary;
    logic        if_flag;
    logic [15:0] psw, cs_in, ip_in, ss_in, sp_in;
    logic        busy, done, clr_if;
    logic [15:0] new_ip, new_cs, new_sp;

    m72_int_seq_if bus ();

    m72_int_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .bus      (bus),
        .boundary (boundary),
        .if_flag  (if_flag),
        .psw      (psw),
        .cs_in    (cs_in),
        .ip_in    (ip_in),
        .ss_in    (ss_in),
        .sp_in    (sp_in),
        .busy     (busy),
        .done     (done),
        .clr_if   (clr_if),
        .new_ip   (new_ip),
        .new_cs   (new_cs),
        .new_sp   (new_sp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [19:0] addr;
        logic [15:0] data;
    } xfer_t;

    typedef struct {
        logic [15:0] ip;
        logic [15:0] cs;
        logic [15:0] sp;
    } res_t;

    xfer_t       exp_bus[$];
    res_t        exp_res[$];
    logic [15:0] mem [int];

    int checks        = 0;
    int failures      = 0;
    int ack_edges     = 0;
    int ce_mode       = 0;
    int wait_n        = 0;
    bit rand_idle_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_rd(input int a);
        int h;
        if (mem.exists(a)) return mem[a];
        h = (a * 40503) ^ 32'h5A3C;
        return h[15:0];
    endfunction

    // Reference model: plain stack arithmetic on a flat 1 MB memory
    task automatic model_push(input logic [15:0] ss, input logic [15:0] sp,
                              input logic [15:0] p, input logic [15:0] c,
                              input logic [15:0] i, input logic [8:0] vec);
        int          base;
        int          s;
        int          a;
        logic [15:0] vals [3];
        xfer_t       x;
        res_t        r;
        vals[0] = p; vals[1] = c; vals[2] = i;
        base = ss;
        base = base * 16;
        s    = sp;
        for (int k = 0; k < 3; k++) begin
            s      = (s + 65536 - 2) % 65536;
            a      = (base + s) % (1 << 20);
            x.wr   = 1'b1;
            x.addr = a[19:0];
            x.data = vals[k];
            exp_bus.push_back(x);
            mem[a] = vals[k];
        end
        a      = vec;
        x.wr   = 1'b0;
        x.addr = a[19:0];
        x.data = 16'h0000;
        exp_bus.push_back(x);
        r.ip   = mem_rd(a);
        a      = a + 2;
        x.addr = a[19:0];
        exp_bus.push_back(x);
        r.cs   = mem_rd(a);
        r.sp   = s[15:0];
        exp_res.push_back(r);
    endtask

    // ce generator
    initial begin
        int ph;
        ph = 0;
        ce = 1'b1;
        forever begin
            @(posedge clk); #1;
            ph++;
            case (ce_mode)
                0:       ce = 1'b1;
                1:       ce = ((ph % 3) == 0);
                default: ce = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Memory responder: wait_n cycles of bus_ack=0 before each completion
    initial begin
        bit fire;
        int cnt;
        cnt         = 0;
        bus.bus_ack = 1'b0;
        bus.bus_din = 16'h0000;
        forever begin
            @(negedge clk);
            fire = ce && bus.bus_req && bus.bus_ack;
            @(posedge clk); #1;
            if (fire) cnt = 0;
            if (bus.bus_req) begin
                if (cnt >= wait_n) begin
                    bus.bus_ack = 1'b1;
                    bus.bus_din = bus.bus_wr ? 16'($urandom) : mem_rd(int'(bus.bus_addr));
                end else begin
                    bus.bus_ack = 1'b0;
                    bus.bus_din = 16'($urandom);
                    cnt++;
                end
            end else begin
                cnt         = 0;
                bus.bus_ack = rand_idle_ack ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.bus_din = 16'($urandom);
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        xfer_t x;
        res_t  r;
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                if (bus.int_ack === 1'b1) chk("int_ack_only_when_busy", 32'(busy), 32'd1);
                if (bus.int_ack === 1'b1 && ce === 1'b1) ack_edges++;
                if (bus.bus_req === 1'b1) begin
                    chk("bus_req_phase", 32'({busy, bus.int_ack, done}), 32'b100);
                    if (exp_bus.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL bus_unexpected: addr %0h present, none expected", bus.bus_addr);
                    end else begin
                        x = exp_bus[0];
                        chk("bus_wr",   32'(bus.bus_wr),   32'(x.wr));
                        chk("bus_addr", 32'(bus.bus_addr), 32'(x.addr));
                        if (x.wr) chk("bus_dout", 32'(bus.bus_dout), 32'(x.data));
                        if (ce === 1'b1 && bus.bus_ack === 1'b1) void'(exp_bus.pop_front());
                    end
                end
                if (done === 1'b1) begin
                    chk("clr_if_with_done", 32'(clr_if), 32'd1);
                    if (ce === 1'b1) begin
                        if (exp_res.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL done_unexpected: new_ip %0h, none expected", new_ip);
                        end else begin
                            r = exp_res.pop_front();
                            chk("new_ip", 32'(new_ip), 32'(r.ip));
                            chk("new_cs", 32'(new_cs), 32'(r.cs));
                            chk("new_sp", 32'(new_sp), 32'(r.sp));
                        end
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        boundary    = 1'b0;
        if_flag     = 1'b0;
        bus.int_req = 1'b0;
    endtask

    task automatic start_seq(input logic [15:0] ss, input logic [15:0] sp,
                             input logic [15:0] p, input logic [15:0] c,
                             input logic [15:0] i, input logic [8:0] vec,
                             output int cyc);
        model_push(ss, sp, p, c, i, vec);
        ack_edges = 0;
        @(posedge clk); #1;
        ss_in = ss; sp_in = sp; psw = p; cs_in = c; ip_in = i;
        bus.int_vector = vec;
        bus.int_req    = 1'b1;
        boundary       = 1'b1;
        if_flag        = 1'b1;
        cyc = 0;
        while (busy !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (busy !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL start_timeout: busy %b required 1", busy);
        end
        bus.int_req = 1'b0;
    endtask

    task automatic finish_seq(input int cyc0, input bit chk_lat);
        int cyc;
        int done_cyc;
        cyc      = cyc0;
        done_cyc = -1;
        while (cyc < 3000) begin
            if (done === 1'b1) begin
                if (done_cyc < 0) done_cyc = cyc;
                idle_inputs();
            end else if (busy === 1'b1) begin
                // Requests and register changes while busy must be ignored
                bus.int_req    = 1'($urandom_range(0, 1));
                boundary       = 1'($urandom_range(0, 1));
                if_flag        = 1'($urandom_range(0, 1));
                bus.int_vector = 9'($urandom);
                psw = 16'($urandom); cs_in = 16'($urandom); ip_in = 16'($urandom);
                ss_in = 16'($urandom); sp_in = 16'($urandom);
            end else begin
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        idle_inputs();
        if (chk_lat) chk("done_latency", 32'(done_cyc), 32'(7 + 5 * wait_n));
        else         chk("done_seen", 32'(done_cyc > 0), 32'd1);
        chk("int_ack_ce_edges", 32'(ack_edges), 32'd1);
        chk("bus_queue_drained", 32'(exp_bus.size()), 32'd0);
        chk("res_queue_drained", 32'(exp_res.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input logic [15:0] ss, input logic [15:0] sp,
                           input logic [15:0] p, input logic [15:0] c,
                           input logic [15:0] i, input logic [8:0] vec,
                           input bit chk_lat);
        int cyc;
        start_seq(ss, sp, p, c, i, vec, cyc);
        finish_seq(cyc, chk_lat);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_int_ack"},  32'(bus.int_ack),  32'd0);
        chk({tag, "_busy"},     32'(busy),         32'd0);
        chk({tag, "_bus_req"},  32'(bus.bus_req),  32'd0);
        chk({tag, "_bus_wr"},   32'(bus.bus_wr),   32'd0);
        chk({tag, "_done"},     32'(done),         32'd0);
        chk({tag, "_clr_if"},   32'(clr_if),       32'd0);
        chk({tag, "_bus_addr"}, 32'(bus.bus_addr), 32'd0);
        chk({tag, "_bus_dout"}, 32'(bus.bus_dout), 32'd0);
        chk({tag, "_new_ip"},   32'(new_ip),       32'd0);
        chk({tag, "_new_cs"},   32'(new_cs),       32'd0);
        chk({tag, "_new_sp"},   32'(new_sp),       32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit bad;
        int cyc;
        reset_n = 1'b0;
        idle_inputs();
        bus.int_vector = 9'h000;
        psw = 16'h0; cs_in = 16'h0; ip_in = 16'h0; ss_in = 16'h0; sp_in = 16'h0;
        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Basic sequence
        mem[32'h80] = 16'h1234;
        mem[32'h82] = 16'h5678;
        run_seq(16'h1000, 16'h0100, 16'hF202, 16'h2000, 16'h0345, 9'h080, 1'b1);
        chk("basic_new_ip", 32'(new_ip), 32'h1234);
        chk("basic_new_cs", 32'(new_cs), 32'h5678);
        chk("basic_new_sp", 32'(new_sp), 32'h00FA);

        // Gating: IF clear, then not at a boundary
        for (int ph = 0; ph < 2; ph++) begin
            @(posedge clk); #1;
            bus.int_req = 1'b1;
            boundary    = (ph == 1) ? 1'b0 : 1'b1;
            if_flag     = (ph == 1) ? 1'b1 : 1'b0;
            bad = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk); #1;
                if (bus.int_ack !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            end
            chk(ph == 0 ? "gate_if_flag" : "gate_boundary", 32'(bad), 32'd0);
            idle_inputs();
        end

        // Wait states
        wait_n = 3;
        run_seq(16'h1000, 16'h0100, 16'hF202, 16'h2000, 16'h0345, 9'h080, 1'b1);
        wait_n = 0;

        // Stack wrap
        run_seq(16'hFFFF, 16'h0002, 16'h1111, 16'h2222, 16'h3333, 9'h040, 1'b1);
        chk("wrap_new_sp", 32'(new_sp), 32'hFFFC);

        // Reset in PUSH_CS
        start_seq(16'h3000, 16'h0200, 16'hAAAA, 16'hC5C5, 16'h0777, 9'h0C0, cyc);
        idle_inputs();
        bad = 1'b1;
        for (int k = 0; k < 50 && bad; k++) begin
            @(negedge clk);
            if (bus.bus_req === 1'b1 && bus.bus_wr === 1'b1 && bus.bus_dout === 16'hC5C5) bad = 1'b0;
        end
        chk("reached_push_cs", 32'(bad), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        exp_bus.delete();
        exp_res.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_seq(16'h1000, 16'h0100, 16'hF202, 16'h2000, 16'h0345, 9'h080, 1'b1);

        // ce gated 1-of-3
        ce_mode = 1;
        run_seq(16'h1000, 16'h0100, 16'hF202, 16'h2000, 16'h0345, 9'h080, 1'b0);
        chk("cegate_new_ip", 32'(new_ip), 32'h1234);
        chk("cegate_new_cs", 32'(new_cs), 32'h5678);
        chk("cegate_new_sp", 32'(new_sp), 32'h00FA);

        // Randomised sequences
        ce_mode       = 2;
        rand_idle_ack = 1'b1;
        for (int n = 0; n < 20; n++) begin
            wait_n = $urandom_range(0, 2);
            run_seq(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), 9'($urandom), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/m72_int_seq.md
# m72_int_seq

CPU-side interrupt acceptance sequencer for the M72 V30 core; the consumer end of the PIC's `int_req` / `int_vector` / `int_ack` handshake. At an instruction boundary with interrupts enabled, it:
- acknowledges the pending request and latches the vector;
- pushes PSW, CS and IP onto the stack;
- fetches the new IP:CS pair from the vector table over the CPU bus;
- hands the results back to the execution unit.

## Interface
Parameters: none.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ce` in 1: clock enable. All state advances only on `clk` edges with `ce=1`.
- `int_req` in 1: request from the PIC.
- `int_vector` in 9: vector-table byte address from the PIC. Stable while `int_req`=1.
- `int_ack` out 1: acknowledge to the PIC.
- `boundary` in 1: the core is at an instruction boundary and may be interrupted.
- `if_flag` in 1: interrupt enable flag.
- `psw`, `cs_in`, `ip_in`, `ss_in`, `sp_in` in 16 each: current core registers.
- `busy` out 1: sequence in progress; the core stalls.
- `bus_req` out 1: bus transfer request.
- `bus_wr` out 1: 1 = write, 0 = read.
- `bus_addr` out 20: physical word address.
- `bus_dout` out 16: write data.
- `bus_din` in 16: read data.
- `bus_ack` in 1: transfer complete.
- `done` out 1: one-cycle pulse; `new_ip`, `new_cs`, `new_sp` are valid this cycle.
- `new_ip`, `new_cs`, `new_sp` out 16 each: register values for the core to load.
- `clr_if` out 1: pulse coincident with `done`; the core clears IF and TF.

## Operation
- States: IDLE → ACK → PUSH_PSW → PUSH_CS → PUSH_IP → RD_IP → RD_CS → DONE → IDLE.
- **IDLE**
  - Trigger: `boundary & if_flag & int_req` sampled on a `ce` edge.
  - On trigger: latch `int_vector` into `vec`, latch `ss_in`/`sp_in`/`psw`/`cs_in`/`ip_in`, set `busy`=1, go to ACK.
  - Otherwise: no effect.
- **ACK**
  - `int_ack`=1 for exactly one `ce` cycle, then go to PUSH_PSW.
  - Interrupt state is taken from `vec`. A deassertion of `int_req` after the trigger is ignored.
- **Push states** (PUSH_PSW, PUSH_CS, PUSH_IP)
  - On entry, `sp` is decremented by 2 (16-bit wrap).
  - `bus_addr` = ({ss,4'h0} + {4'h0,sp}) mod 2^20.
  - `bus_wr`=1; `bus_dout` = PSW, CS, IP respectively.
- **RD_IP**
  - `bus_addr` = {11'h0, vec}; `bus_wr`=0.
  - Capture `bus_din` into `new_ip` on ack.
- **RD_CS**
  - `bus_addr` = {11'h0, vec} + 2; `bus_wr`=0.
  - Capture `bus_din` into `new_cs` on ack.
- **Bus handshake**
  - `bus_req`, `bus_wr`, `bus_addr` and `bus_dout` are registered and held stable until a `ce` edge samples `bus_ack`=1 with `bus_req`=1.
  - On that edge the transfer completes and the next state's transfer is presented in the following cycle.
  - `bus_ack` is ignored when `bus_req`=0.
- **DONE**
  - `done`=1 and `clr_if`=1 for one cycle; `new_sp` = `sp` after the three pushes.
  - Return to IDLE with `busy`=0.
  - A new request may be accepted in IDLE on the next boundary.
- `new_*` registers hold their values until the next DONE.

## Timing
- Reset values: `int_ack`, `busy`, `bus_req`, `bus_wr`, `done` and `clr_if` = 0; `bus_addr`, `bus_dout` and `new_*` = 0; state = IDLE.
- Reset mid-sequence: return to IDLE immediately. No `done`, no partial commit, `bus_req` drops asynchronously.
- `ce`=0: all outputs and state are frozen, including a pending `int_ack` or `bus_req`.
- Latency with `bus_ack` tied high:
  - trigger edge N → `int_ack` during cycle N+1;
  - first `bus_req` during N+2;
  - five transfers occupy N+2..N+6;
  - `done` during N+7.
- Each wait cycle with `bus_ack`=0 adds exactly one cycle.
- `int_ack` is never asserted outside ACK. `bus_req` is never asserted in IDLE, ACK or DONE.
- Simultaneous `boundary & if_flag & int_req` while `busy`: ignored. Only IDLE samples requests.

## Test plan
- **Basic sequence.** ss=0x1000, sp=0x0100, psw=0xF202, cs=0x2000, ip=0x0345, vector=0x080, `bus_ack` tied 1, memory[0x00080]=0x1234, memory[0x00082]=0x5678.
  - Required writes: 0x100FE←F202, 0x100FC←2000, 0x100FA←0345.
  - Required reads: 0x00080, 0x00082.
  - `done` at N+7 with new_ip=0x1234, new_cs=0x5678, new_sp=0x00FA.
- **Gating.** `int_req`=1 with `if_flag`=0, or with `boundary`=0, for 20 cycles → no `int_ack`, `busy` stays 0.
- **Wait states.** `bus_ack` delayed 3 cycles on every transfer → address and data held stable; `done` at N+22.
- **Stack wrap.** ss=0xFFFF, sp=0x0002 → push addresses 0xFFFF0, 0x0FFEE, 0x0FFEC; new_sp=0xFFFC.
- **Reset mid-sequence.** `reset_n` low during PUSH_CS → all outputs 0 immediately; after release, a new request runs a complete sequence.
- **ce gating.** `ce` toggled 1-of-3 during the basic sequence → identical bus transactions and results; `int_ack` high for exactly one `ce` edge.
